// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and frame constants for the boot program loader.
//   loader_state_t : frame FSM states
//   rx_state_t     : UART byte receiver states
//   MAGIC          : frame start byte
//   BYTE_W/WORD_W/LEN_W : frame field widths
package prog_loader_pkg;

    localparam logic [7:0] MAGIC  = 8'hA5;
    localparam int         BYTE_W = 8;
    localparam int         WORD_W = 32;
    localparam int         LEN_W  = 16;

    typedef enum logic [2:0] {
        WAIT_MAGIC,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// uart_rx: 8N1 LSB-first UART byte receiver with a two-flop rx synchroniser.
//   Clock, nReset : system clock, async active-low reset
//   rx            : raw serial line, idle high
//   byteValid     : one-cycle pulse, byteData holds the received byte
//   byteData      : last received byte
//   frameErr      : one-cycle pulse when the stop bit samples low
//
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronised line
//   RX_START | half-bit wait, then re-check the start bit (glitch filter)
//   RX_DATA  | sampling 8 data bits at one-bit intervals
//   RX_STOP  | sampling the stop bit
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              rx,
    output logic              byteValid,
    output logic [BYTE_W-1:0] byteData,
    output logic              frameErr
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_LOAD = TIMER_W'(CLKS_PER_BIT - 1);

    rx_state_t          rxState, rxStateNext;
    logic               rxMeta, rxSync, rxPrev;
    logic [TIMER_W-1:0] bitTimer;
    logic [2:0]         bitIdx;
    logic               timerDone;

    assign timerDone = (bitTimer == '0);

    always_comb begin
        rxStateNext = rxState;
        case (rxState)
            RX_IDLE:  if (rxPrev && !rxSync) rxStateNext = RX_START;
            RX_START: if (timerDone) rxStateNext = rxSync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (timerDone && bitIdx == 3'd7) rxStateNext = RX_STOP;
            RX_STOP:  if (timerDone) rxStateNext = RX_IDLE;
            default:  rxStateNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rxState   <= RX_IDLE;
            rxMeta    <= 1'b1;
            rxSync    <= 1'b1;
            rxPrev    <= 1'b1;
            bitTimer  <= HALF_LOAD;
            bitIdx    <= '0;
            byteData  <= '0;
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            rxState   <= rxStateNext;
            rxMeta    <= rx;
            rxSync    <= rxMeta;
            rxPrev    <= rxSync;
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
            if (rxState == RX_IDLE) begin
                // Preload so the first START check lands half a bit after the edge.
                bitTimer <= HALF_LOAD;
                bitIdx   <= '0;
            end else begin
                bitTimer <= timerDone ? FULL_LOAD : bitTimer - 1'b1;
                if (timerDone && rxState == RX_DATA) begin
                    byteData <= {rxSync, byteData[BYTE_W-1:1]};
                    bitIdx   <= bitIdx + 1'b1;
                end
                if (timerDone && rxState == RX_STOP) begin
                    byteValid <= rxSync;
                    frameErr  <= !rxSync;
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader. Receives a framed program image over UART,
// writes it into program memory and releases the core reset only after a
// checksum-valid image has been written.
//   Clock, nReset        : system clock, async active-low reset
//   rx                   : UART receive line
//   progWe/progAddr/progData : one-cycle program-memory write port
//   coreNReset           : active-low core reset, high only after a good load
//   loadDone             : sticky, valid image loaded
//   loadErr              : sticky until the next MAGIC byte, last frame failed
// Build option: define LOADER_TIMEOUT_EN to abort a frame that stalls for
// TIMEOUT_CYCLES between bytes.
//
//   state      | meaning
//   WAIT_MAGIC | idle, looking for 0xA5
//   LEN_LO     | expecting word-count low byte
//   LEN_HI     | expecting word-count high byte, range check
//   DATA       | assembling little-endian words and writing them
//   CHECK      | expecting XOR checksum byte
//   DONE       | image valid, core released; only nReset leaves
//   ERROR      | one cycle: flag error, then back to WAIT_MAGIC
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int MEM_WORDS    = 1024,
    parameter int ADDR_W       = 10
`ifdef LOADER_TIMEOUT_EN
    ,parameter int TIMEOUT_CYCLES = 5_000_000
`endif
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              rx,
    output logic              progWe,
    output logic [ADDR_W-1:0] progAddr,
    output logic [WORD_W-1:0] progData,
    output logic              coreNReset,
    output logic              loadDone,
    output logic              loadErr
);

    loader_state_t     state, stateNext;
    logic              byteValid, frameErr;
    logic [BYTE_W-1:0] byteData;
    logic [BYTE_W-1:0] lenLo;
    logic [LEN_W-1:0]  lenFull;
    logic [ADDR_W:0]   wordCount;
    logic [ADDR_W:0]   wordIdx;
    logic [1:0]        byteCnt;
    logic [23:0]       wordLow;
    logic [BYTE_W-1:0] xorAcc;
    logic              inFrame;
    logic              timeout;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uRx (
        .Clock     (Clock),
        .nReset    (nReset),
        .rx        (rx),
        .byteValid (byteValid),
        .byteData  (byteData),
        .frameErr  (frameErr)
    );

    assign lenFull = {byteData, lenLo};
    assign inFrame = (state inside {LEN_LO, LEN_HI, DATA, CHECK});

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] idleTimer;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            idleTimer <= 32'(TIMEOUT_CYCLES - 1);
        else if (byteValid || !inFrame)
            idleTimer <= 32'(TIMEOUT_CYCLES - 1);
        else if (idleTimer != '0)
            idleTimer <= idleTimer - 1'b1;
    end

    assign timeout = inFrame && (idleTimer == '0);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        case (state)
            WAIT_MAGIC: if (byteValid && byteData == MAGIC) stateNext = LEN_LO;
            LEN_LO:     if (byteValid) stateNext = LEN_HI;
            LEN_HI: begin
                if (byteValid) begin
                    if (lenFull > LEN_W'(MEM_WORDS)) stateNext = ERROR;
                    else if (lenFull == '0)          stateNext = CHECK;
                    else                             stateNext = DATA;
                end
            end
            // Leave only once the last write strobe is on the port, so
            // progWe is never seen outside DATA.
            DATA:       if (wordIdx == wordCount) stateNext = CHECK;
            CHECK:      if (byteValid) stateNext = (byteData == xorAcc) ? DONE : ERROR;
            DONE:       stateNext = DONE;
            ERROR:      stateNext = WAIT_MAGIC;
            default:    stateNext = WAIT_MAGIC;
        endcase
        if (inFrame && (frameErr || timeout))
            stateNext = ERROR;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= WAIT_MAGIC;
            progWe     <= 1'b0;
            progAddr   <= '0;
            progData   <= '0;
            coreNReset <= 1'b0;
            loadDone   <= 1'b0;
            loadErr    <= 1'b0;
            lenLo      <= '0;
            wordCount  <= '0;
            wordIdx    <= '0;
            byteCnt    <= '0;
            wordLow    <= '0;
            xorAcc     <= '0;
        end else begin
            state  <= stateNext;
            progWe <= 1'b0;
            case (state)
                WAIT_MAGIC: begin
                    if (byteValid && byteData == MAGIC) begin
                        loadErr <= 1'b0;
                        xorAcc  <= '0;
                        wordIdx <= '0;
                        byteCnt <= '0;
                    end
                end
                LEN_LO: begin
                    if (byteValid) begin
                        lenLo  <= byteData;
                        xorAcc <= xorAcc ^ byteData;
                    end
                end
                LEN_HI: begin
                    if (byteValid) begin
                        wordCount <= lenFull[ADDR_W:0];
                        xorAcc    <= xorAcc ^ byteData;
                    end
                end
                DATA: begin
                    if (byteValid) begin
                        xorAcc  <= xorAcc ^ byteData;
                        byteCnt <= byteCnt + 1'b1;
                        if (byteCnt == 2'd3) begin
                            progWe   <= 1'b1;
                            progAddr <= wordIdx[ADDR_W-1:0];
                            progData <= {byteData, wordLow};
                            wordIdx  <= wordIdx + 1'b1;
                        end else begin
                            wordLow <= {byteData, wordLow[23:8]};
                        end
                    end
                end
                DONE:    coreNReset <= 1'b1;
                default: ;
            endcase
            if (stateNext == ERROR) loadErr  <= 1'b1;
            if (stateNext == DONE)  loadDone <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
// Uses a short UART bit time so full frames fit in a few thousand cycles.
// With LOADER_TIMEOUT_EN defined, also exercises the idle timeout at 1000 cycles.
module tb_prog_loader;

    localparam int CPB    = 16;
    localparam int ADDR_W = 10;

    logic              Clock = 1'b0;
    logic              nReset = 1'b0;
    logic              rx = 1'b1;
    logic              progWe;
    logic [ADDR_W-1:0] progAddr;
    logic [31:0]       progData;
    logic              coreNReset, loadDone, loadErr;

    int checks = 0;
    int failures = 0;

    logic [ADDR_W-1:0] wrAddr [16];
    logic [31:0]       wrData [16];
    int                wrCount = 0;

    always #5 Clock = ~Clock;

    prog_loader #(
        .CLKS_PER_BIT (CPB),
        .MEM_WORDS    (1024),
        .ADDR_W       (ADDR_W)
`ifdef LOADER_TIMEOUT_EN
        ,.TIMEOUT_CYCLES (1000)
`endif
    ) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .rx         (rx),
        .progWe     (progWe),
        .progAddr   (progAddr),
        .progData   (progData),
        .coreNReset (coreNReset),
        .loadDone   (loadDone),
        .loadErr    (loadErr)
    );

    // Write-port monitor, sampled on the inactive edge.
    always @(negedge Clock) begin
        if (progWe) begin
            if (wrCount < 16) begin
                wrAddr[wrCount] = progAddr;
                wrData[wrCount] = progData;
            end
            wrCount = wrCount + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bitWait();
        repeat (CPB) @(posedge Clock);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        bitWait();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            bitWait();
        end
        rx = stopBit;
        bitWait();
        rx = 1'b1;
        repeat (4) @(posedge Clock);
    endtask

    task automatic doReset();
        nReset = 1'b0;
        repeat (3) @(posedge Clock);
        nReset = 1'b1;
        repeat (3) @(posedge Clock);
    endtask

    // A5 02 00 | 78 56 34 12 | EF BE AD DE | CHK
    // CHK = 02^00 ^ (78^56^34^12 = 08) ^ (EF^BE^AD^DE = 22) = 0x28
    task automatic sendTwoWordFrame(input logic [7:0] chk);
        sendByte(8'hA5, 1'b1);
        sendByte(8'h02, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h78, 1'b1);
        sendByte(8'h56, 1'b1);
        sendByte(8'h34, 1'b1);
        sendByte(8'h12, 1'b1);
        sendByte(8'hEF, 1'b1);
        sendByte(8'hBE, 1'b1);
        sendByte(8'hAD, 1'b1);
        sendByte(8'hDE, 1'b1);
        sendByte(chk, 1'b1);
        repeat (10) @(posedge Clock);
    endtask

    initial begin
        int base;

        // Reset state
        nReset = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_progWe", progWe, 0);
        check("rst_progAddr", progAddr, 0);
        check("rst_progData", progData, 0);
        check("rst_coreNReset", coreNReset, 0);
        check("rst_loadDone", loadDone, 0);
        check("rst_loadErr", loadErr, 0);
        nReset = 1'b1;
        repeat (3) @(posedge Clock);

        // 1: good two-word frame
        sendTwoWordFrame(8'h28);
        @(negedge Clock);
        check("t1_wrCount", wrCount, 2);
        check("t1_addr0", wrAddr[0], 0);
        check("t1_data0", wrData[0], 32'h12345678);
        check("t1_addr1", wrAddr[1], 1);
        check("t1_data1", wrData[1], 32'hDEADBEEF);
        check("t1_loadDone", loadDone, 1);
        check("t1_coreNReset", coreNReset, 1);
        check("t1_loadErr", loadErr, 0);

        // DONE ignores further frames
        sendByte(8'hA5, 1'b1);
        sendByte(8'h01, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h11, 1'b1);
        sendByte(8'h22, 1'b1);
        sendByte(8'h33, 1'b1);
        sendByte(8'h44, 1'b1);
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        check("done_noWrite", wrCount, 2);
        check("done_loadDone", loadDone, 1);

        // 2: empty image
        doReset();
        base = wrCount;
        sendByte(8'hA5, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h00, 1'b1);
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        check("t2_noWrite", wrCount - base, 0);
        check("t2_loadDone", loadDone, 1);
        check("t2_coreNReset", coreNReset, 1);

        // 3: bad checksum, then correct resend
        doReset();
        base = wrCount;
        sendTwoWordFrame(8'h00);
        @(negedge Clock);
        check("t3_wrCount", wrCount - base, 2);
        check("t3_loadErr", loadErr, 1);
        check("t3_coreNReset", coreNReset, 0);
        check("t3_loadDone", loadDone, 0);
        sendTwoWordFrame(8'h28);
        @(negedge Clock);
        check("t3r_wrCount", wrCount - base, 4);
        check("t3r_addr", wrAddr[base + 2], 0);
        check("t3r_data", wrData[base + 3], 32'hDEADBEEF);
        check("t3r_loadDone", loadDone, 1);
        check("t3r_loadErr", loadErr, 0);
        check("t3r_coreNReset", coreNReset, 1);

        // 4: N = 1025 rejected
        doReset();
        base = wrCount;
        sendByte(8'hA5, 1'b1);
        sendByte(8'h01, 1'b1);
        sendByte(8'h04, 1'b1);
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        check("t4_noWrite", wrCount - base, 0);
        check("t4_loadErr", loadErr, 1);
        check("t4_loadDone", loadDone, 0);

        // 5a: quarter-bit glitch mid-frame is not a byte
        doReset();
        sendByte(8'hA5, 1'b1);
        rx = 1'b0;
        repeat (CPB / 4) @(posedge Clock);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge Clock);
        sendByte(8'h00, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h00, 1'b1);
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        check("t5_glitchDone", loadDone, 1);
        check("t5_glitchErr", loadErr, 0);

        // 5b: framing error inside DATA
        doReset();
        base = wrCount;
        sendByte(8'hA5, 1'b1);
        sendByte(8'h02, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h78, 1'b1);
        sendByte(8'h56, 1'b1);
        sendByte(8'h34, 1'b1);
        sendByte(8'h12, 1'b1);
        sendByte(8'hEF, 1'b1);
        sendByte(8'hBE, 1'b0);
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        check("t5_ferrErr", loadErr, 1);
        check("t5_ferrWrites", wrCount - base, 1);
        check("t5_ferrCore", coreNReset, 0);

        // 6: reset mid-frame, then full reload
        doReset();
        sendByte(8'hA5, 1'b1);
        sendByte(8'h02, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h78, 1'b1);
        sendByte(8'h56, 1'b1);
        nReset = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("t6_progWe", progWe, 0);
        check("t6_progAddr", progAddr, 0);
        check("t6_progData", progData, 0);
        check("t6_coreNReset", coreNReset, 0);
        check("t6_loadDone", loadDone, 0);
        check("t6_loadErr", loadErr, 0);
        nReset = 1'b1;
        repeat (3) @(posedge Clock);
        base = wrCount;
        sendTwoWordFrame(8'h28);
        @(negedge Clock);
        check("t6_wrCount", wrCount - base, 2);
        check("t6_data0", wrData[base], 32'h12345678);
        check("t6_loadDone", loadDone, 1);
        check("t6_coreOut", coreNReset, 1);

`ifdef LOADER_TIMEOUT_EN
        // 7: stall after LEN_HI
        doReset();
        sendByte(8'hA5, 1'b1);
        sendByte(8'h01, 1'b1);
        sendByte(8'h00, 1'b1);
        repeat (900) @(posedge Clock);
        @(negedge Clock);
        check("t7_beforeTimeout", loadErr, 0);
        repeat (200) @(posedge Clock);
        @(negedge Clock);
        check("t7_timeoutErr", loadErr, 1);
        check("t7_timeoutCore", coreNReset, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
